// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------------------------
// alu_mul_seq
//
// Multi-cycle unsigned multiplier sequencer. While a multiply is in flight it owns the shared
// execute-stage ALU and computes a * b mod 2^W by shift-and-add. It issues one ALU operation
// per cycle: a shift-left of the multiplicand by the current bit index, then an add of that
// partial product into the running product.
//
// Optional feature (compile-time macro MUL_SEQ_EARLY_EXIT_EN):
//   When defined, the scan stops as soon as no set multiplier bits remain at or above the
//   current index. Results are identical; only latency changes.
//
// Ports:
//   i_clk         in  1          clock, rising edge
//   i_rst_n       in  1          asynchronous active-low reset
//   i_start       in  1          request a multiply (sampled only when o_busy = 0)
//   i_a           in  W          multiplicand, latched at accept
//   i_b           in  W          multiplier, latched at accept
//   o_busy        out 1          multiply in progress (SCAN / SHIFT / ADD)
//   o_done        out 1          one-cycle pulse; o_result valid from this cycle onward
//   o_result      out W          product mod 2^W, held until the next o_done
//   o_alu_op      out AluOpWidth operation to the shared ALU
//   o_alu_a       out W          ALU operand 1
//   o_alu_b       out W          ALU operand 2
//   i_alu_result  in  W          ALU output, combinational from o_alu_op / o_alu_a / o_alu_b
// ---------------------------------------------------------------------------------------------

`ifndef RegWidth
`define RegWidth 16
`endif
`ifndef AluOpWidth
`define AluOpWidth 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 0
`endif
`ifndef ALU_OP_SL
`define ALU_OP_SL 2
`endif

module alu_mul_seq #(
    parameter int unsigned W = `RegWidth
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [W-1:0]           i_a,
    input  logic [W-1:0]           i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [W-1:0]           o_result,
    output logic [`AluOpWidth-1:0] o_alu_op,
    output logic [W-1:0]           o_alu_a,
    output logic [W-1:0]           o_alu_b,
    input  logic [W-1:0]           i_alu_result
);

    localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(W - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    localparam logic [`AluOpWidth-1:0] OpAdd = `AluOpWidth'(`ALU_OP_ADD);
    localparam logic [`AluOpWidth-1:0] OpSl  = `AluOpWidth'(`ALU_OP_SL);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StShift,
        StAdd,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [W-1:0]    r_m;
    logic [W-1:0]    w_m_d;
    logic [W-1:0]    r_q;
    logic [W-1:0]    w_q_d;
    logic [W-1:0]    r_prod;
    logic [W-1:0]    w_prod_d;
    logic [W-1:0]    r_tmp;
    logic [W-1:0]    w_tmp_d;
    logic [IdxW-1:0] r_idx;
    logic [IdxW-1:0] w_idx_d;
    logic [W-1:0]    r_result;
    logic [W-1:0]    w_result_d;

    logic            w_cur_bit;
    assign w_cur_bit = r_q[r_idx];

`ifdef MUL_SEQ_EARLY_EXIT_EN
    // No set multiplier bits remain at or above the current index.
    logic w_upper_zero;
    assign w_upper_zero = ((r_q >> r_idx) == '0);
`endif

    // -----------------------------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_m      <= '0;
            r_q      <= '0;
            r_prod   <= '0;
            r_tmp    <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_m      <= w_m_d;
            r_q      <= w_q_d;
            r_prod   <= w_prod_d;
            r_tmp    <= w_tmp_d;
            r_idx    <= w_idx_d;
            r_result <= w_result_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state and ALU drive
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state;
        w_m_d      = r_m;
        w_q_d      = r_q;
        w_prod_d   = r_prod;
        w_tmp_d    = r_tmp;
        w_idx_d    = r_idx;
        w_result_d = r_result;
        o_alu_op   = OpAdd;
        o_alu_a    = '0;
        o_alu_b    = '0;

        unique case (r_state)
            StIdle, StDone: begin
                // A start in the DONE cycle is accepted; done still pulses this cycle.
                if (i_start) begin
                    w_m_d     = i_a;
                    w_q_d     = i_b;
                    w_prod_d  = '0;
                    w_idx_d   = '0;
                    w_state_d = StScan;
                end else begin
                    w_state_d = StIdle;
                end
            end

            StScan: begin
                if (w_cur_bit) begin
                    w_state_d = StShift;
                end
`ifdef MUL_SEQ_EARLY_EXIT_EN
                else if (w_upper_zero) begin
                    w_state_d = StDone;
                end
`endif
                else if (r_idx == IdxLast) begin
                    w_state_d = StDone;
                end else begin
                    w_idx_d = r_idx + IdxOne;
                end
            end

            StShift: begin
                // Partial product m << idx.
                o_alu_op  = OpSl;
                o_alu_a   = r_m;
                o_alu_b   = W'(r_idx);
                w_tmp_d   = i_alu_result;
                w_state_d = StAdd;
            end

            StAdd: begin
                o_alu_op = OpAdd;
                o_alu_a  = r_prod;
                o_alu_b  = r_tmp;
                w_prod_d = i_alu_result;
                if (r_idx == IdxLast) begin
                    w_state_d = StDone;
                end else begin
                    w_idx_d   = r_idx + IdxOne;
                    w_state_d = StScan;
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Result is captured on entry to DONE, so it changes only in the DONE cycle.
        if (w_state_d == StDone) begin
            w_result_d = w_prod_d;
        end
    end

    assign o_busy   = (r_state == StScan) || (r_state == StShift) || (r_state == StAdd);
    assign o_done   = (r_state == StDone);
    assign o_result = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// ---------------------------------------------------------------------------------------------
// tb_alu_mul_seq
//
// Self-checking bench for alu_mul_seq at W = 16. A behavioural ALU answers the sequencer's
// requests; expected products, latencies and flags come from plain arithmetic on the operands.
// Honours MUL_SEQ_EARLY_EXIT_EN for the expected latency.
// ---------------------------------------------------------------------------------------------

`ifndef AluOpWidth
`define AluOpWidth 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 0
`endif
`ifndef ALU_OP_SL
`define ALU_OP_SL 2
`endif

module tb_alu_mul_seq;

    localparam int W = 16;
    localparam logic [`AluOpWidth-1:0] OpAdd = `AluOpWidth'(`ALU_OP_ADD);
    localparam logic [`AluOpWidth-1:0] OpSl  = `AluOpWidth'(`ALU_OP_SL);

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [W-1:0]           a;
    logic [W-1:0]           b;
    logic                   busy;
    logic                   done;
    logic [W-1:0]           result;
    logic [`AluOpWidth-1:0] alu_op;
    logic [W-1:0]           alu_a;
    logic [W-1:0]           alu_b;
    logic [W-1:0]           alu_result;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_result;  // last product the bench expects to be held on o_result

    alu_mul_seq #(
        .W (W)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_a          (a),
        .i_b          (b),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_alu_op     (alu_op),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result)
    );

    // Behavioural shared ALU.
    always_comb begin
        alu_result = '0;
        if (alu_op == OpSl) begin
            alu_result = alu_a << alu_b;
        end else if (alu_op == OpAdd) begin
            alu_result = alu_a + alu_b;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles from accept edge to the done cycle.
    function automatic int exp_lat(input logic [15:0] bv);
        int p;
        int h;
        int scans;
        p     = $countones(bv);
        h     = -1;
        scans = W;
        for (int i = 0; i < W; i++) begin
            if (bv[i]) h = i;
        end
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (h < 0) scans = 1;
        else if (h + 2 > W) scans = W;
        else scans = h + 2;
`endif
        return 1 + scans + 2 * p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle T+1 of an accepted multiply. Returns in the done cycle.
    task automatic wait_done(input logic [15:0] av, input logic [15:0] bv, input int poke,
                             input bit chain, input logic [15:0] na, input logic [15:0] nb,
                             input string tag);
        logic [15:0] prod;
        int          lat;
        int          seen_at;
        int          busy_low;
        int          res_moved;
        int          bad_sl_a;
        bit          saw_sl;
        prod      = av * bv;
        lat       = exp_lat(bv);
        seen_at   = -1;
        busy_low  = 0;
        res_moved = 0;
        bad_sl_a  = 0;
        saw_sl    = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (done) begin
                seen_at = cyc;
                break;
            end
            if (busy !== 1'b1) busy_low++;
            if (result !== exp_result) res_moved++;
            if (alu_op == OpSl) begin
                saw_sl = 1'b1;
                if (alu_a !== av) bad_sl_a++;
            end
            if (poke != 0 && cyc == poke) begin
                start = 1'b1;
                a     = 16'h0009;
                b     = 16'h0009;
            end else if (poke != 0 && cyc == poke + 1) begin
                start = 1'b0;
            end
            tick();
        end
        check({tag, ".latency"}, 32'(seen_at + 1), 32'(lat + 1));
        check({tag, ".result"}, 32'(result), 32'(prod));
        check({tag, ".busy_in_done"}, 32'(busy), 32'(0));
        check({tag, ".busy_gaps"}, 32'(busy_low), 32'(0));
        check({tag, ".result_held"}, 32'(res_moved), 32'(0));
        check({tag, ".shift_operand"}, 32'(bad_sl_a), 32'(0));
        check({tag, ".shift_issued"}, 32'(saw_sl), 32'(bv != 16'h0));
        exp_result = prod;
        if (chain) begin
            a = na;
            b = nb;
        end
    endtask

    task automatic run(input logic [15:0] av, input logic [15:0] bv, input int poke,
                       input string tag);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        wait_done(av, bv, poke, 1'b0, 16'h0, 16'h0, tag);
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'(0));
        check({tag, ".idle_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int          found;
        int          done_in_rst;
        logic [15:0] ra;
        logic [15:0] rb;

        n_vec      = 0;
        n_err      = 0;
        exp_result = 16'h0;
        rst_n      = 1'b0;
        start      = 1'b0;
        a          = '0;
        b          = '0;

        #3;
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.result", 32'(result), 32'(0));
        check("rst.alu_op", 32'(alu_op), 32'(OpAdd));
        check("rst.alu_a", 32'(alu_a), 32'(0));
        check("rst.alu_b", 32'(alu_b), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run(16'h0007, 16'h0005, 0, "mul7x5");
        run(16'h0003, 16'h0000, 0, "mul3x0");
        run(16'hFFFF, 16'h0002, 0, "wrapFFFFx2");
        run(16'h0100, 16'h0100, 0, "wrap100x100");
        run(16'h0002, 16'h0003, 2, "ignore_start");

        // Abort in the ADD cycle of 5 * 6.
        start = 1'b1;
        a     = 16'h0005;
        b     = 16'h0006;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (alu_op == OpSl) begin
                found = 1;
                break;
            end
            tick();
        end
        check("abort.reach_shift", 32'(found), 32'(1));
        tick();
        check("abort.add_op", 32'(alu_op), 32'(OpAdd));
        check("abort.add_b", 32'(alu_b), 32'(16'h0005 << 1));
        #2;
        rst_n = 1'b0;
        #1;
        exp_result = 16'h0;
        check("abort.busy", 32'(busy), 32'(0));
        check("abort.done", 32'(done), 32'(0));
        check("abort.result", 32'(result), 32'(0));
        check("abort.alu_op", 32'(alu_op), 32'(OpAdd));
        done_in_rst = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done !== 1'b0) done_in_rst++;
        end
        rst_n = 1'b1;
        tick();
        if (done !== 1'b0) done_in_rst++;
        check("abort.no_done", 32'(done_in_rst), 32'(0));
        check("abort.result_after", 32'(result), 32'(0));
        run(16'h0004, 16'h0004, 0, "after_abort");

        // Back-to-back: start held high; second operands presented in the DONE cycle.
        start = 1'b1;
        a     = 16'h0002;
        b     = 16'h0002;
        tick();
        wait_done(16'h0002, 16'h0002, 0, 1'b1, 16'h0003, 16'h0003, "b2b_first");
        tick();
        start = 1'b0;
        check("b2b.restart_busy", 32'(busy), 32'(1));
        wait_done(16'h0003, 16'h0003, 0, 1'b0, 16'h0, 16'h0, "b2b_second");
        tick();
        check("b2b.done_pulse", 32'(done), 32'(0));

        // Randomized operands; multiplier width varies to exercise the latency rule.
        for (int n = 0; n < 12; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            run(ra, rb, 0, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle unsigned multiplier sequencer that owns the single shared `alu` instance during a multiply. It computes `a * b` mod 2^`RegWidth` by shift-and-add, issuing `ALU_OP_SL` and `ALU_OP_ADD` operations to the ALU one per cycle. It sits beside the ALU in the execute stage: the core drives `start` for a MUL instruction and stalls on `busy`. While the block is idle, its ALU-driving outputs are don't-care; the core's mux selects them only while `busy` is high.

## Interface
- `W`, default `` `RegWidth ``, data width; the index counter is clog2(W) bits.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a multiply; sampled only when `busy`=0.
- `a` in W: multiplicand, latched at accept.
- `b` in W: multiplier, latched at accept.
- `busy` out 1: a multiply is in progress.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle onward.
- `result` out W: product mod 2^W, held until the next `done`.
- `aluOp` out `` `AluOpWidth ``: operation to the ALU.
- `aluA` out W: ALU operand 1.
- `aluB` out W: ALU operand 2.
- `aluResult` in W: ALU output, combinational from `aluOp`/`aluA`/`aluB`.

## Operation
- Internal registers: `m` (multiplicand), `q` (multiplier), `prod`, `tmp`, `idx`, and the state.
- States and transitions:
  - IDLE, DONE: `start`=1 latches `a`→`m` and `b`→`q`, sets `prod`=0 and `idx`=0, then goes to SCAN.
  - SCAN: if `q[idx]`=1, go to SHIFT. Otherwise, if `idx`=W-1 go to DONE; else `idx`++ and stay in SCAN.
  - SHIFT: drive `aluOp`=`ALU_OP_SL`, `aluA`=`m`, `aluB`=`idx` zero-extended to W. Set `tmp`←`aluResult`, go to ADD.
  - ADD: drive `aluOp`=`ALU_OP_ADD`, `aluA`=`prod`, `aluB`=`tmp`. Set `prod`←`aluResult`. If `idx`=W-1 go to DONE; else `idx`++ and go to SCAN.
  - On entry to DONE: `result`←final `prod`.
  - DONE: `done`=1. Without a new `start`, go to IDLE next cycle.
- Outside SHIFT/ADD: `aluOp`=`ALU_OP_ADD`, `aluA`=0, `aluB`=0.
- `busy`=1 exactly in SCAN, SHIFT and ADD.
- Arithmetic: all sums and shifts are W-bit and wrap silently; there is no overflow flag.
- `start` while `busy`=1 is ignored; the operands are not relatched.
- `start` in the DONE cycle is accepted: `done` still pulses that cycle and the next cycle is SCAN.

## Timing
- Reset values (asynchronous, take effect immediately):
  - state IDLE; `busy`=0, `done`=0, `result`=0.
  - `m`, `q`, `prod`, `tmp`, `idx` all 0.
  - `aluOp`=`ALU_OP_ADD`, `aluA`=0, `aluB`=0.
- Reset asserted mid-multiply aborts it: no `done` pulse, and `result` reads 0.
- Accept at edge T; the first SCAN is cycle T+1.
- Latency without early exit: `done` at T+1+W+2·popcount(b).
- `busy` rises in cycle T+1 and falls in the DONE cycle.
- `result` changes only in the DONE cycle.

## Configuration
- `MUL_SEQ_EARLY_EXIT_EN` defined:
  - In SCAN, if `q[W-1:idx]`=0, go directly to DONE.
  - Latency becomes T+1 + (number of SCAN cycles up to and including the exiting one) + 2·popcount(b).
  - For b=0, `done` at T+2.
- `MUL_SEQ_EARLY_EXIT_EN` undefined: every bit index is scanned and latency is data-dependent only through popcount.
- Results are identical in both modes.

## Test plan
All scenarios use W=16.
- a=7, b=5, start at T → `result`=35.
  - Early exit off: `done` at T+21.
  - Early exit on: `done` at T+9.
  - `busy` high for every cycle between T and `done`.
- a=3, b=0 → `result`=0.
  - Early exit off: `done` at T+17.
  - Early exit on: `done` at T+2.
  - `aluOp` never equals `ALU_OP_SL`.
- a=0xFFFF, b=2 → `result`=0xFFFE (wrap). Also a=0x0100, b=0x0100 → `result`=0x0000.
- Accept a=2, b=3. Then pulse `start` with a=9, b=9 while `busy`=1 → ignored; `result`=6 with unchanged latency.
- Start a=5, b=6 and assert `rst_n`=0 during ADD → `busy`/`done`/`result`=0 immediately, with no `done` pulse.
  - After release, a=4, b=4 → `result`=16.
- Back-to-back: `start` held high with a=2, b=2, then a=3, b=3 presented in the DONE cycle → `done` pulses for both, `result`=4 then 9.
